// File: rtl/sd_sector_write_scheduler.sv
// Packs UART rx bytes into two ping-pong 512-byte sector buffers and hands full (or idle-flushed,
// padded) sectors to the SD data-input controller one 16-bit word per wr_req.
module sd_sector_write_scheduler #(
  parameter logic [31:0] START_ADDR   = 32'h0,
  parameter int unsigned IDLE_TIMEOUT = 50_000_000,
  parameter logic [7:0]  PAD_BYTE     = 8'hFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_flag,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [31:0] sector_count,
  output logic        overflow
);

  typedef enum logic [1:0] {BufEmpty, BufFull, BufWriting} buf_state_e;
  typedef enum logic [2:0] {StIdle, StStart, StWaitBusy, StWriting, StDone} wr_state_e;

  wr_state_e  state_q, state_d;
  buf_state_e buf_state_q [2];
  logic [9:0] valid_bytes_q [2];

  logic        fill_sel_q;
  logic [8:0]  byte_idx_q;
  logic [31:0] idle_cnt_q;
  logic        overflow_q;

  logic        rd_sel_q;
  logic [7:0]  word_idx_q;
  logic [9:0]  wait_cnt_q;
  logic [31:0] wr_addr_q;
  logic [31:0] sector_count_q;
  logic [15:0] wr_data_q;

  // Byte lanes of both buffers; buffer select is the index MSB.
  logic [7:0] mem_hi [512];
  logic [7:0] mem_lo [512];

  logic       fill_free;
  logic       byte_accept;
  logic       byte_drop;
  logic       flush_fire;
  logic       fill_done;
  logic [9:0] fill_valid;
  logic       in_start;
  logic       in_done;

  // ---------------------------------------------------------------------------------------------
  // Fill side
  // ---------------------------------------------------------------------------------------------
  assign fill_free   = (buf_state_q[fill_sel_q] == BufEmpty);
  assign byte_accept = rx_flag && fill_free;
  assign byte_drop   = rx_flag && !fill_free;
  // A byte arriving on the expiry cycle wins over the timeout.
  assign flush_fire  = (IDLE_TIMEOUT != 0) && !rx_flag && (byte_idx_q != 9'd0) &&
                       (idle_cnt_q == 32'(IDLE_TIMEOUT));
  assign fill_done   = (byte_accept && (byte_idx_q == 9'd511)) || flush_fire;
  assign fill_valid  = flush_fire ? {1'b0, byte_idx_q} : 10'd512;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fill_sel_q <= 1'b0;
      byte_idx_q <= '0;
      idle_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (byte_drop) begin
        overflow_q <= 1'b1;
      end
      if (fill_done) begin
        fill_sel_q <= ~fill_sel_q;
        byte_idx_q <= '0;
      end else if (byte_accept) begin
        byte_idx_q <= byte_idx_q + 9'd1;
      end
      if (rx_flag || fill_done) begin
        idle_cnt_q <= '0;
      end else if (byte_idx_q != 9'd0) begin
        idle_cnt_q <= idle_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (byte_accept) begin
      if (!byte_idx_q[0]) begin
        mem_hi[{fill_sel_q, byte_idx_q[8:1]}] <= rx_data;
      end else begin
        mem_lo[{fill_sel_q, byte_idx_q[8:1]}] <= rx_data;
      end
    end
  end

  // Fill only ever completes an EMPTY buffer while START/DONE act on the read buffer, so the
  // updates below never collide on the same entry.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_state_q[i]   <= BufEmpty;
        valid_bytes_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fill_done && (fill_sel_q == 1'(i))) begin
          buf_state_q[i]   <= BufFull;
          valid_bytes_q[i] <= fill_valid;
        end else if (in_start && (rd_sel_q == 1'(i))) begin
          buf_state_q[i] <= BufWriting;
        end else if (in_done && (rd_sel_q == 1'(i))) begin
          buf_state_q[i] <= BufEmpty;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (buf_state_q[rd_sel_q] == BufFull) state_d = StStart;
      StStart:    state_d = StWaitBusy;
      StWaitBusy: begin
        if (wr_busy) begin
          state_d = StWriting;
        end else if (wait_cnt_q == 10'd1023) begin
          state_d = StStart;
        end
      end
      StWriting:  if (!wr_busy) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_en    = (state_q == StStart);
    in_start = (state_q == StStart);
    in_done  = (state_q == StDone);
  end

  // ---------------------------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------------------------
  logic [8:0]  rd_idx;
  logic [9:0]  pos_hi;
  logic [9:0]  pos_lo;
  logic [15:0] rd_word;

  always_comb begin
    rd_idx  = {rd_sel_q, word_idx_q};
    pos_hi  = {1'b0, word_idx_q, 1'b0};
    pos_lo  = {1'b0, word_idx_q, 1'b1};
    rd_word = {PAD_BYTE, PAD_BYTE};
    if (pos_hi < valid_bytes_q[rd_sel_q]) rd_word[15:8] = mem_hi[rd_idx];
    if (pos_lo < valid_bytes_q[rd_sel_q]) rd_word[7:0]  = mem_lo[rd_idx];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_sel_q       <= 1'b0;
      word_idx_q     <= '0;
      wait_cnt_q     <= '0;
      wr_addr_q      <= START_ADDR;
      sector_count_q <= '0;
      wr_data_q      <= '0;
    end else begin
      wait_cnt_q <= (state_q == StWaitBusy) ? wait_cnt_q + 10'd1 : 10'd0;
      if ((state_q == StWriting) && wr_req) begin
        wr_data_q <= rd_word;
        if (word_idx_q != 8'hFF) begin
          word_idx_q <= word_idx_q + 8'd1;
        end
      end
      if (in_done) begin
        wr_addr_q      <= wr_addr_q + 32'd1;
        sector_count_q <= sector_count_q + 32'd1;
        rd_sel_q       <= ~rd_sel_q;
        word_idx_q     <= '0;
      end
    end
  end

  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign sector_count = sector_count_q;
  assign overflow     = overflow_q;

endmodule
